jump_input_ctrl: RTL

- Upstream stage of the player vertical-movement block.
- Turns three raw push-button keys into one-clock, one-hot jump/drop commands (`operation`) and generates the frame-rate `update` tick.
- Locks out new commands until the movement sequence started by the previous command has had its full number of update ticks.
- `operation[2:0]` and `update` connect directly to the movement block: bit0 big jump, bit1 small jump, bit2 drop.

---
 rtl/jump_input_ctrl_if.sv | 21 ++
 rtl/jump_input_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/jump_input_ctrl_if.sv
// Signal bundle between the jump input controller and its neighbours: game enable,
// raw keys in, one-hot command pulse, frame tick and busy flag out.
interface jump_input_ctrl_if;
    logic       enable;
    logic       key_big;
    logic       key_small;
    logic       key_drop;
    logic [2:0] operation;
    logic       update;
    logic       busy;

    modport master (
        output enable, key_big, key_small, key_drop,
        input  operation, update, busy
    );

    modport slave (
        input  enable, key_big, key_small, key_drop,
        output operation, update, busy
    );
endinterface

// File: rtl/jump_input_ctrl.sv
// Debounces three active-low jump keys into one-hot command pulses, generates the frame
// tick and locks out new commands until the running move has used up its frame ticks.
module jump_input_ctrl #(
    parameter int unsigned TICK_DIV        = 833333,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned BIG_LEN         = 10,
    parameter int unsigned SMALL_LEN       = 15,
    parameter int unsigned DROP_LEN        = 9
) (
    input logic              clk,
    input logic              rst_n,
    jump_input_ctrl_if.slave bus
);

    localparam int unsigned MAX_BS  = (BIG_LEN > SMALL_LEN) ? BIG_LEN : SMALL_LEN;
    localparam int unsigned MAX_LEN = (MAX_BS > DROP_LEN) ? MAX_BS : DROP_LEN;
    localparam int unsigned LOCK_W  = $clog2(MAX_LEN + 1);
    localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StBusy} state_e;

    // Key vector order matches the one-hot command: bit0 big, bit1 small, bit2 drop.
    logic [2:0]             key_raw;
    logic [2:0]             sync1_q, sync2_q;
    logic [2:0]             level_q, level_d;
    logic [2:0][DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [2:0]             press_q, press_d;
    logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic                   update_q, update_d;
    state_e                 state_q, state_d;
    logic [2:0]             cmd_q, cmd_d;
    logic [LOCK_W-1:0]      lock_q, lock_d;
    logic [2:0]             op_q, op_d;
    logic                   busy_q, busy_d;

    assign key_raw = {bus.key_drop, bus.key_small, bus.key_big};

    always_comb begin
        level_d   = level_q;
        deb_cnt_d = deb_cnt_q;
        for (int k = 0; k < 3; k++) begin
            if (sync2_q[k] == level_q[k]) begin
                deb_cnt_d[k] = '0;
            end else if (deb_cnt_q[k] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d[k]   = ~level_q[k];
                deb_cnt_d[k] = '0;
            end else begin
                deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
            end
        end
        // Only a released-to-pressed flip is a press event.
        press_d = level_q & ~level_d;
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        update_d   = 1'b0;
        if (bus.enable) begin
            if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
                tick_cnt_d = '0;
                update_d   = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        lock_d  = lock_q;
        unique case (state_q)
            StIdle: begin
                if (bus.enable && (press_q != 3'b000)) begin
                    state_d = StIssue;
                    if (press_q[0]) begin
                        cmd_d  = 3'b001;
                        lock_d = LOCK_W'(BIG_LEN);
                    end else if (press_q[1]) begin
                        cmd_d  = 3'b010;
                        lock_d = LOCK_W'(SMALL_LEN);
                    end else begin
                        cmd_d  = 3'b100;
                        lock_d = LOCK_W'(DROP_LEN);
                    end
                end
            end
            StIssue: state_d = StBusy;
            StBusy: begin
                if (update_q) begin
                    lock_d = lock_q - 1'b1;
                    if (lock_q == LOCK_W'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        op_d   = (state_q == StIssue) ? cmd_q : 3'b000;
        busy_d = (state_q != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 3'b111;
            sync2_q    <= 3'b111;
            level_q    <= 3'b111;
            deb_cnt_q  <= '0;
            press_q    <= 3'b000;
            tick_cnt_q <= '0;
            update_q   <= 1'b0;
            state_q    <= StIdle;
            cmd_q      <= 3'b000;
            lock_q     <= '0;
            op_q       <= 3'b000;
            busy_q     <= 1'b0;
        end else begin
            sync1_q    <= key_raw;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            deb_cnt_q  <= deb_cnt_d;
            press_q    <= press_d;
            tick_cnt_q <= tick_cnt_d;
            update_q   <= update_d;
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            lock_q     <= lock_d;
            op_q       <= op_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.operation = op_q;
    assign bus.update    = update_q;
    assign bus.busy      = busy_q;

endmodule
